// File: rtl/sa_tile_driver_flat_pkg.sv
// Shared definitions for the systolic tile driver and its peer array:
// FP32 word width and the driver FSM state encoding.
package sa_tile_driver_flat_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_C = 2'd2,
    ST_DONE   = 2'd3
  } tile_state_e;

endpackage

// File: rtl/sa_tile_driver_flat.sv
// Streams one tile's reduction steps (A column, B row per k) into a peer
// systolic array, then waits for every PE result before pulsing tile_done.
module sa_tile_driver_flat
  import sa_tile_driver_flat_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int KMAX = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tile_start,
  input  logic [15:0]                K_len,
  output logic                       tile_busy,
  output logic                       tile_done,
  input  logic [M*KMAX*FP32_W-1:0]   W_tile_flat,
  input  logic [KMAX*N*FP32_W-1:0]   X_tile_flat,
  output logic                       step_valid,
  output logic [M*FP32_W-1:0]        a_row_flat,
  output logic [N*FP32_W-1:0]        b_col_flat,
  output logic                       k_first,
  output logic                       k_last,
  input  logic                       step_ready,
  input  logic [M*N*FP32_W-1:0]      c_out_flat,
  input  logic [M*N-1:0]             c_valid_flat,
  output tile_state_e                state_dbg
);

  localparam int KW = $clog2(KMAX + 1);

  // Handshake: a step transfers on a rising edge where step_valid and
  // step_ready are both 1; while step_valid=1 and step_ready=0 the payload
  // and flags stay frozen because k_q only moves on a transfer.

  tile_state_e   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] klen_q, klen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   klen_clamp;
  logic          in_issue;
  logic          is_last;
  logic          unused_c_out;

  assign klen_clamp = (32'(K_len) > KMAX) ? 16'(KMAX) : K_len;
  assign in_issue   = (state_q == ST_ISSUE);
  assign is_last    = (k_q == klen_q - KW'(1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    klen_d  = klen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tile_start) begin
          klen_d = KW'(klen_clamp);
          k_d    = '0;
          if (klen_clamp == 16'd0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (step_ready) begin
          k_d = k_q + KW'(1);
          if (is_last) state_d = ST_WAIT_C;
        end
      end
      ST_WAIT_C: begin
        if (&c_valid_flat) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      klen_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      klen_q  <= klen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Index muxes: payload lanes are zero whenever no step is being offered.
  always_comb begin
    a_row_flat = '0;
    b_col_flat = '0;
    if (in_issue) begin
      for (int i = 0; i < M; i++)
        a_row_flat[i*FP32_W +: FP32_W] = W_tile_flat[(i*KMAX + int'(k_q))*FP32_W +: FP32_W];
      for (int j = 0; j < N; j++)
        b_col_flat[j*FP32_W +: FP32_W] = X_tile_flat[(int'(k_q)*N + j)*FP32_W +: FP32_W];
    end
  end

  assign step_valid   = in_issue;
  assign k_first      = in_issue && (k_q == '0);
  assign k_last       = in_issue && is_last;
  assign tile_busy    = busy_q;
  assign tile_done    = done_q;
  assign state_dbg    = state_q;
  assign unused_c_out = ^c_out_flat;

endmodule

// File: tb/tb_sa_tile_driver_flat.sv
// Directed bench for sa_tile_driver_flat: the bench stands in for the
// systolic array, scoreboarding every accepted step against its own tables.
module tb_sa_tile_driver_flat;
  import sa_tile_driver_flat_pkg::*;

  localparam int M    = 8;
  localparam int N    = 8;
  localparam int KMAX = 8;
  localparam int AW   = M*32;
  localparam int BW   = N*32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   tile_start = 1'b0;
  logic [15:0]            K_len = '0;
  logic                   tile_busy, tile_done;
  logic [M*KMAX*32-1:0]   W_tile_flat = '0;
  logic [KMAX*N*32-1:0]   X_tile_flat = '0;
  logic                   step_valid;
  logic [AW-1:0]          a_row_flat;
  logic [BW-1:0]          b_col_flat;
  logic                   k_first, k_last;
  logic                   step_ready = 1'b0;
  logic [M*N*32-1:0]      c_out_flat = '0;
  logic [M*N-1:0]         c_valid_flat = '0;
  tile_state_e            state_dbg;

  sa_tile_driver_flat #(.M(M), .N(N), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .K_len(K_len),
    .tile_busy(tile_busy), .tile_done(tile_done),
    .W_tile_flat(W_tile_flat), .X_tile_flat(X_tile_flat),
    .step_valid(step_valid), .a_row_flat(a_row_flat), .b_col_flat(b_col_flat),
    .k_first(k_first), .k_last(k_last), .step_ready(step_ready),
    .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] w_mem [M][KMAX];
  logic [31:0] x_mem [KMAX][N];
  logic [31:0] aval [4] = '{32'h3f800000, 32'h40000000, 32'h3f000000, 32'h40400000};
  logic [31:0] bval [4] = '{32'h3f800000, 32'h3f000000, 32'h40000000, 32'h40400000};
  logic [31:0] crow [4] = '{32'h41400000, 32'h41100000, 32'h41200000, 32'h41340000};
  logic [AW-1:0] exp_q   [$];
  logic [BW-1:0] exp_b_q [$];
  real acc [M][N];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] w);
    real m;
    int  e;
    if (w[30:0] == 31'd0) begin
      f2r = 0.0;
    end else begin
      m   = 1.0 + real'(w[22:0]) / 8388608.0;
      e   = int'(w[30:23]) - 127;
      f2r = (w[31] ? -m : m) * (2.0 ** e);
    end
  endfunction

  function automatic logic [AW-1:0] exp_a(input int k);
    logic [AW-1:0] r;
    for (int i = 0; i < M; i++) r[i*32 +: 32] = w_mem[i][k];
    return r;
  endfunction

  function automatic logic [BW-1:0] exp_b(input int k);
    logic [BW-1:0] r;
    for (int j = 0; j < N; j++) r[j*32 +: 32] = x_mem[k][j];
    return r;
  endfunction

  // driver tasks
  task automatic load_tiles();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < KMAX; k++) W_tile_flat[(i*KMAX+k)*32 +: 32] = w_mem[i][k];
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) X_tile_flat[(k*N+j)*32 +: 32] = x_mem[k][j];
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < KMAX; k++) w_mem[i][k] = aval[(k+i)%4];
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) x_mem[k][j] = bval[(k+j)%4];
    load_tiles();
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < KMAX; k++) w_mem[i][k] = $urandom_range(32'hffff_ffff, 0);
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) x_mem[k][j] = $urandom_range(32'hffff_ffff, 0);
    load_tiles();
  endtask

  // Runs one tile; eff is the step count the driver must issue.
  task automatic run_tile(input int klen, input int eff, input int stall_step,
                          input bit poke, input string tag);
    int steps, dones, stall_cnt, cyc, done_cyc, extra;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    exp_q.delete();
    exp_b_q.delete();
    for (int k = 0; k < eff; k++) begin
      exp_q.push_back(exp_a(k));
      exp_b_q.push_back(exp_b(k));
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) acc[i][j] = 0.0;
    @(negedge clk);
    K_len = 16'(klen);
    tile_start = 1'b1;
    step_ready = 1'b1;
    @(negedge clk);
    tile_start = 1'b0;
    if (eff > 0) check({tag, " busy_on_accept"}, 256'(tile_busy), 256'(1));
    steps = 0; dones = 0; stall_cnt = 0; cyc = 0; done_cyc = -1;
    while (dones == 0 && cyc < 100) begin
      tile_start = 1'b0;
      if (tile_done) begin
        dones++;
        done_cyc = cyc;
        check({tag, " busy_at_done"}, 256'(tile_busy), 256'(0));
        c_valid_flat = '0;
      end else if (step_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra_step"}, 256'(steps + 1), 256'(eff));
          steps++;
        end else if (steps == stall_step && stall_cnt < 3) begin
          step_ready = 1'b0;
          stall_cnt++;
          check({tag, " held_a"}, a_row_flat, exp_q[0]);
          check({tag, " held_b"}, b_col_flat, exp_b_q[0]);
          check({tag, " held_first"}, 256'(k_first), 256'(steps == 0));
          check({tag, " held_last"}, 256'(k_last), 256'(steps == eff-1));
        end else begin
          step_ready = 1'b1;
          ea = exp_q.pop_front();
          eb = exp_b_q.pop_front();
          check({tag, " a_row"}, a_row_flat, ea);
          check({tag, " b_col"}, b_col_flat, eb);
          check({tag, " k_first"}, 256'(k_first), 256'(steps == 0));
          check({tag, " k_last"}, 256'(k_last), 256'(steps == eff-1));
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              acc[i][j] += f2r(a_row_flat[i*32 +: 32]) * f2r(b_col_flat[j*32 +: 32]);
          steps++;
        end
        if (poke && cyc == 1) tile_start = 1'b1;
      end else begin
        if (steps == eff && eff > 0) c_valid_flat = '1;
        if (poke && cyc == eff) tile_start = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    tile_start = 1'b0;
    check({tag, " step_count"}, 256'(steps), 256'(eff));
    check({tag, " done_seen"}, 256'(dones), 256'(1));
    if (eff == 0) check({tag, " done_latency_le2"}, 256'(done_cyc >= 0 && done_cyc <= 1), 256'(1));
    check({tag, " done_single"}, 256'(tile_done), 256'(0));
    check({tag, " busy_after"}, 256'(tile_busy), 256'(0));
    check({tag, " idle_after"}, 256'(state_dbg), 256'(ST_IDLE));
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (tile_done || step_valid || tile_busy) extra++;
    end
    check({tag, " quiet_after"}, 256'(extra), 256'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 256'(state_dbg), 256'(ST_IDLE));
    check({tag, " outs"}, 256'({tile_busy, tile_done, step_valid, k_first, k_last}), 256'(0));
    check({tag, " a_row"}, a_row_flat, '0);
    check({tag, " b_col"}, b_col_flat, '0);
  endtask

  initial begin : main
    int extra;
    fill_pattern();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 8x8, K=4 pattern tile; bench plays the array and returns the known C
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        c_out_flat[(i*N+j)*32 +: 32] = crow[(j + 4 - (i % 4)) % 4];
    run_tile(4, 4, -1, 1'b0, "k4");
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("k4 c%0d%0d_x4", i, j), 256'($rtoi(acc[i][j] * 4.0)),
              256'($rtoi(f2r(crow[(j + 4 - (i % 4)) % 4]) * 4.0)));
    c_out_flat = '0;

    fill_random();
    run_tile(1, 1, -1, 1'b0, "k1");
    run_tile(6, 6, 2, 1'b0, "stall");
    run_tile(3, 3, -1, 1'b1, "poke");
    run_tile(0, 0, -1, 1'b0, "k0");
    run_tile(20, KMAX, -1, 1'b0, "clamp");

    // asynchronous reset in the middle of ISSUE
    @(negedge clk);
    K_len = 16'd5;
    tile_start = 1'b1;
    step_ready = 1'b1;
    @(negedge clk);
    tile_start = 1'b0;
    @(negedge clk);
    check("midrst in_issue", 256'(step_valid), 256'(1));
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (tile_done || step_valid || tile_busy) extra++;
    end
    check("midrst no_done", 256'(extra), 256'(0));

    run_tile(2, 2, -1, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_tile_driver_flat.md
SA_TILE_DRIVER_FLAT -- requirements
Module: sa_tile_driver_flat

Interface
REQ-001 SHALL have parameter M, default 8, meaning the number of rows (A elements per step).
REQ-002 SHALL have parameter N, default 8, meaning the number of columns (B elements per step).
REQ-003 SHALL have parameter KMAX, default 1024, meaning the maximum reduction depth held in the tile buffers.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port tile_start, input, 1 bit: request to process one tile.
REQ-007 SHALL have port K_len, input, 16 bits: reduction length, sampled at tile start.
REQ-008 SHALL have port tile_busy, output, 1 bit: high from tile acceptance until the done pulse.
REQ-009 SHALL have port tile_done, output, 1 bit: single-cycle tile-complete pulse.
REQ-010 SHALL have port W_tile_flat, input, M*KMAX*32 bits: element (i,k) at bits [(i*KMAX+k)*32 +: 32].
REQ-011 SHALL have port X_tile_flat, input, KMAX*N*32 bits: element (k,j) at bits [(k*N+j)*32 +: 32].
REQ-012 SHALL have port step_valid, output, 1 bit: the step payload is valid.
REQ-013 SHALL have port a_row_flat, output, M*32 bits: lane i carries W(i,k).
REQ-014 SHALL have port b_col_flat, output, N*32 bits: lane j carries X(k,j).
REQ-015 SHALL have port k_first, output, 1 bit: the current step has k==0.
REQ-016 SHALL have port k_last, output, 1 bit: the current step has k==K_len-1.
REQ-017 SHALL have port step_ready, input, 1 bit: systolic_array_os_flat accepts the step.
REQ-018 SHALL have port c_out_flat, input, M*N*32 bits: result from the array; observed only, not modified.
REQ-019 SHALL have port c_valid_flat, input, M*N bits: per-PE result valid.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_C and DONE.
REQ-021 SHALL, in IDLE with tile_start=1 at a clock edge, latch K_len, clamped to KMAX, set k=0 and tile_busy=1, and enter ISSUE; if the latched K_len is 0 it SHALL enter DONE instead.
REQ-022 SHALL ignore tile_start whenever the FSM is not in IDLE.
REQ-023 SHALL, in ISSUE, drive step_valid=1 with a_row_flat and b_col_flat selected combinationally from the current k, and k_first and k_last decoded from k.
REQ-024 SHALL advance a step only when step_valid and step_ready are both 1, incrementing k.
REQ-025 SHALL hold the step payload, k_first and k_last stable while step_valid=1 and step_ready=0.
REQ-026 SHALL move to WAIT_C when the k_last step is accepted and then drive step_valid=0.
REQ-027 SHALL, in WAIT_C, move to DONE in the cycle after all bits of c_valid_flat are 1.
REQ-028 SHALL, in DONE, pulse tile_done=1 for exactly one cycle, clear tile_busy in the same cycle, and return to IDLE.
REQ-029 SHALL drive step_valid=0, k_first=0, k_last=0 and zero payloads outside ISSUE.
REQ-030 SHALL issue exactly K_len steps per tile, with k_first=1 on step 0 only and k_last=1 on step K_len-1 only; with K_len=1 both flags SHALL be 1 on the same step.
REQ-031 SHALL not compute arithmetically; all FP32 multiply-accumulate work belongs to systolic_array_os_flat, which clears its accumulators on k_first and asserts c_valid after k_last.

Reset
REQ-032 SHALL, while rst=0, asynchronously force the state to IDLE, k=0, the latched K_len to 0, and tile_busy, tile_done, step_valid, k_first and k_last to 0.
REQ-033 SHALL make reset asserted mid-tile abandon the tile, so no tile_done is produced for it.

Structure
REQ-034 SHALL place the FSM state enum and the FP32 word width (32) in a shared package used by the driver and the array.
REQ-035 SHALL contain no sub-module: one counter, one FSM and the index muxes; systolic_array_os_flat is a peer instance, not a child.

Verification
REQ-036 SHALL cover M=N=8, K_len=4 with A(i,k)=aval[(k+i)%4], where aval={3f800000,40000000,3f000000,40400000}, and B(k,j)=bval[(k+j)%4], where bval={3f800000,3f000000,40000000,40400000}; the required response is row 0 of C = 41400000, 41100000, 41200000, 41340000 repeated, with each subsequent row rotated right by one and rows 4-7 equal to rows 0-3, followed by tile_done.
REQ-037 SHALL cover K_len=1; the required response is exactly one step with k_first=1 and k_last=1.
REQ-038 SHALL cover step_ready held low for 3 cycles mid-tile; the required response is a payload held constant and no step lost or duplicated.
REQ-039 SHALL cover tile_start pulsed while busy; the required response is that it is ignored, giving a single tile_done.
REQ-040 SHALL cover K_len=0; the required response is no step_valid, tile_done within 2 cycles, and tile_busy=0 afterwards.
REQ-041 SHALL cover rst=0 during ISSUE; the required response is all outputs at 0 immediately and the FSM in IDLE.
